// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its two-requester arbiter.
//   - ALU opcode constants (primary names plus the alternate ADD encodings)
//   - is_legal_cop(): true for every opcode the ALU defines a result for
//   - state_t: arbiter FSM state encoding
package alu_pkg;

  localparam logic [3:0] COP_ZERO  = 4'b0000;
  localparam logic [3:0] COP_ADD   = 4'b0001;
  localparam logic [3:0] COP_SUB   = 4'b0010;
  localparam logic [3:0] COP_MOVB  = 4'b0011;
  localparam logic [3:0] COP_EQ    = 4'b0100;
  // Alternate encodings that also perform A+B.
  localparam logic [3:0] COP_ADD_6 = 4'b0110;
  localparam logic [3:0] COP_ADD_7 = 4'b0111;
  localparam logic [3:0] COP_ADD_E = 4'b1110;
  localparam logic [3:0] COP_ADD_F = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_cop(input logic [3:0] cop);
    case (cop)
      COP_ZERO, COP_ADD, COP_SUB, COP_MOVB, COP_EQ,
      COP_ADD_6, COP_ADD_7, COP_ADD_E, COP_ADD_F: is_legal_cop = 1'b1;
      default:                                    is_legal_cop = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// alu: purely combinational ALU shared by the arbiter.
// Ports:
//   a, b    in  INPUT_WIDTH  operands
//   cop     in  4            opcode (see alu_pkg)
//   result  out INPUT_WIDTH+1  result; top bit is carry (add) / borrow (sub)
// Undefined opcodes yield X (don't-care for synthesis).
module alu
  import alu_pkg::*;
#(
  parameter int INPUT_WIDTH = 16
) (
  input  logic [INPUT_WIDTH-1:0] a,
  input  logic [INPUT_WIDTH-1:0] b,
  input  logic [3:0]             cop,
  output logic [INPUT_WIDTH:0]   result
);

  always_comb begin
    result = '0;
    case (cop)
      COP_ZERO: result = '0;
      COP_ADD, COP_ADD_6, COP_ADD_7, COP_ADD_E, COP_ADD_F:
        result = {1'b0, a} + {1'b0, b};
      // Zero-extended subtraction leaves the borrow in the top bit.
      COP_SUB:  result = {1'b0, a} - {1'b0, b};
      COP_MOVB: result = {1'b0, b};
      COP_EQ:   result = {{INPUT_WIDTH{1'b0}}, (a == b)};
      default:  result = 'x;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with round-robin
// arbitration and a single operation in flight (IDLE -> EXEC -> RESP).
// Optional feature macro: ALU_COP_CHECK_EN (illegal opcodes are blocked from
// the ALU and reported on rsp_err; without it rsp_err does not exist).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/cop    request channels (ready is combinational)
//   rspN_valid/ready            response channels
//   rsp_result, rsp_ovf         registered result and carry/borrow, shared
//   rsp_err                     illegal-opcode flag (ALU_COP_CHECK_EN only)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [3:0]            req0_cop,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [3:0]            req1_cop,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_ovf
`ifdef ALU_COP_CHECK_EN
  ,
  output logic                  rsp_err
`endif
);

  state_t                state;
  logic                  last_grant;  // id of the most recently accepted requester
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [3:0]            op_cop;
  logic                  op_id;
  logic [3:0]            alu_cop;
  logic [DATA_WIDTH:0]   alu_result;
  logic                  grant0;
  logic                  grant1;
  logic                  rsp_done;

  // Round robin: a lone requester always wins; on a conflict the one not
  // granted last goes first. last_grant resets to 1 so req0 wins first.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  // rst_n gating keeps ready low while reset is held, even though the
  // state already reads IDLE.
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;

  assign rsp_done = op_id ? rsp1_ready : rsp0_ready;

`ifdef ALU_COP_CHECK_EN
  logic cop_legal;
  assign cop_legal = is_legal_cop(op_cop);
  // Illegal opcodes never reach the ALU, so its output is always defined.
  assign alu_cop   = cop_legal ? op_cop : COP_ZERO;
`else
  assign alu_cop   = op_cop;
`endif

  alu #(
    .INPUT_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a      (op_a),
    .b      (op_b),
    .cop    (alu_cop),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_cop     <= '0;
      op_id      <= 1'b0;
      rsp_result <= '0;
      rsp_ovf    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
`ifdef ALU_COP_CHECK_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            op_a       <= req1_ready ? req1_a   : req0_a;
            op_b       <= req1_ready ? req1_b   : req0_b;
            op_cop     <= req1_ready ? req1_cop : req0_cop;
            op_id      <= req1_ready;
            last_grant <= req1_ready;
            state      <= EXEC;
          end
        end
        EXEC: begin
`ifdef ALU_COP_CHECK_EN
          rsp_result <= cop_legal ? alu_result[DATA_WIDTH-1:0] : '0;
          rsp_ovf    <= cop_legal ? alu_result[DATA_WIDTH] : 1'b0;
          rsp_err    <= !cop_legal;
`else
          rsp_result <= alu_result[DATA_WIDTH-1:0];
          rsp_ovf    <= alu_result[DATA_WIDTH];
`endif
          rsp0_valid <= !op_id;
          rsp1_valid <= op_id;
          state      <= RESP;
        end
        RESP: begin
          // Result registers are left untouched here so they hold steady
          // for the whole stall.
          if (rsp_done) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter. Inputs are driven at the
// falling edge, outputs sampled there too (away from the rising edge).
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_cop, req1_cop;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_ovf;
`ifdef ALU_COP_CHECK_EN
  logic          rsp_err;
`endif

  int checks;
  int fails;

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cop   (req0_cop),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cop   (req1_cop),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf)
`ifdef ALU_COP_CHECK_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req0_cop = '0;
    req1_a = '0; req1_b = '0; req1_cop = '0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  // One full transaction from a single requester, starting in IDLE at a
  // falling edge, with timing, result and ovf checked inline.
  task automatic run_op(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [3:0] cop, input logic [DW-1:0] exp_res,
                        input logic exp_ovf, input string name);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cop = cop; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_cop = cop; end
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
      fails++;
      $display("FAIL %s_ready: got %b%b need %b", name, req1_ready, req0_ready, (id ? 2'b10 : 2'b01));
    end
    @(negedge clk);  // EXEC
    req0_valid = 0; req1_valid = 0;
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      fails++;
      $display("FAIL %s_early_valid: got %b%b need 00", name, rsp1_valid, rsp0_valid);
    end
    @(negedge clk);  // RESP
    checks++;
    if ({rsp1_valid, rsp0_valid} !== (id ? 2'b10 : 2'b01)) begin
      fails++;
      $display("FAIL %s_rsp_valid: got %b%b need %b", name, rsp1_valid, rsp0_valid, (id ? 2'b10 : 2'b01));
    end
    checks++;
    if (rsp_result !== exp_res || rsp_ovf !== exp_ovf) begin
      fails++;
      $display("FAIL %s_result: got %h ovf %b need %h ovf %b", name, rsp_result, rsp_ovf, exp_res, exp_ovf);
    end
`ifdef ALU_COP_CHECK_EN
    checks++;
    if (rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL %s_err: got %b need 0", name, rsp_err);
    end
`endif
    $display("op %s: id=%0d a=%h b=%h cop=%b -> result=%h ovf=%b", name, id, a, b, cop, rsp_result, rsp_ovf);
    if (id) rsp1_ready = 1; else rsp0_ready = 1;
    @(negedge clk);  // back in IDLE
    rsp0_ready = 0; rsp1_ready = 0;
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      fails++;
      $display("FAIL %s_rsp_clear: got %b%b need 00", name, rsp1_valid, rsp0_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_ovf} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b%b vld=%b%b res=%h ovf=%b need all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_ovf);
    end
    $display("reset: outputs rdy=%b%b vld=%b%b res=%h", req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result);
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single_op();
    run_op(1'b0, 16'h0003, 16'h0004, COP_ADD, 16'h0007, 1'b0, "add0");
    run_op(1'b0, 16'h1234, 16'hABCD, COP_MOVB, 16'hABCD, 1'b0, "movb0");
    run_op(1'b1, 16'h9999, 16'h1111, COP_ZERO, 16'h0000, 1'b0, "zero1");
    run_op(1'b1, 16'h0005, 16'h0006, COP_EQ, 16'h0000, 1'b0, "neq1");
  endtask

  task automatic test_overflow();
    run_op(1'b1, 16'hFFFF, 16'h0001, COP_ADD, 16'h0000, 1'b1, "add_carry");
    run_op(1'b1, 16'h0001, 16'h0002, COP_SUB, 16'hFFFF, 1'b1, "sub_borrow");
    run_op(1'b0, 16'h0010, 16'h0003, COP_SUB, 16'h000D, 1'b0, "sub_plain");
    run_op(1'b0, 16'h8000, 16'h8001, 4'b1111, 16'h0001, 1'b1, "addF_carry");
  endtask

  task automatic test_conflict();
    do_reset();
    @(negedge clk);
    req0_valid = 1; req0_a = 16'd5; req0_b = 16'd5; req0_cop = COP_EQ;
    req1_valid = 1; req1_a = 16'd5; req1_b = 16'd5; req1_cop = COP_EQ;
    rsp0_ready = 1; rsp1_ready = 1;
    // Both requesters hold valid; grants must alternate 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++) begin
      logic exp_id;
      exp_id = (i % 2 == 1);
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL conflict_grant%0d: got %b%b need %b", i, req1_ready, req0_ready, (exp_id ? 2'b10 : 2'b01));
      end
      @(negedge clk);  // EXEC
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        fails++;
        $display("FAIL conflict_exec_ready%0d: got %b%b need 00", i, req1_ready, req0_ready);
      end
      @(negedge clk);  // RESP
      checks++;
      if ({rsp1_valid, rsp0_valid} !== (exp_id ? 2'b10 : 2'b01) || rsp_result !== 16'h0001) begin
        fails++;
        $display("FAIL conflict_rsp%0d: got vld %b%b res %h need %b res 0001",
                 i, rsp1_valid, rsp0_valid, rsp_result, (exp_id ? 2'b10 : 2'b01));
      end
      $display("conflict %0d: grant=%0d result=%h", i, rsp1_valid, rsp_result);
      @(negedge clk);  // IDLE
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h1111; req0_cop = COP_ADD;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_accept0: got %b need 1", req0_ready);
    end
    @(negedge clk);  // EXEC
    req0_valid = 0;
    req1_valid = 1; req1_a = 16'h0000; req1_b = 16'hBEEF; req1_cop = COP_MOVB;
    @(negedge clk);  // RESP, rsp0_ready held low
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp0_valid !== 1'b1 || rsp_result !== 16'h2345 || rsp_ovf !== 1'b0 || req1_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold%0d: got vld %b res %h ovf %b rdy1 %b need 1 2345 0 0",
                 i, rsp0_valid, rsp_result, rsp_ovf, req1_ready);
      end
      @(negedge clk);
    end
    $display("stall: held result=%h for 5 cycles", rsp_result);
    rsp0_ready = 1;
    @(negedge clk);  // IDLE
    rsp0_ready = 0;
    checks++;
    if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_release: got rdy1 %b vld0 %b need 1 0", req1_ready, rsp0_valid);
    end
    @(negedge clk);  // EXEC
    req1_valid = 0;
    @(negedge clk);  // RESP
    checks++;
    if (rsp1_valid !== 1'b1 || rsp_result !== 16'hBEEF) begin
      fails++;
      $display("FAIL stall_next: got vld1 %b res %h need 1 BEEF", rsp1_valid, rsp_result);
    end
    $display("stall: follow-up req1 result=%h", rsp_result);
    rsp1_ready = 1;
    @(negedge clk);
    rsp1_ready = 0;
  endtask

  task automatic test_reset_mid_op();
    // Leave last_grant = 0 so only a reset can make req0 win the next conflict.
    run_op(1'b0, 16'h0002, 16'h0002, COP_ADD, 16'h0004, 1'b0, "pre_rst");
    req0_valid = 1; req0_a = 16'h00F0; req0_b = 16'h000F; req0_cop = COP_ADD;
    @(negedge clk);  // EXEC
    req0_valid = 0;
    rst_n = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_ovf} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: got rdy=%b%b vld=%b%b res=%h need all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
        fails++;
        $display("FAIL midrst_no_rsp%0d: got %b%b need 00", i, rsp1_valid, rsp0_valid);
      end
    end
    req0_valid = 1; req1_valid = 1;
    req0_cop = COP_MOVB; req0_b = 16'h0A0A;
    req1_cop = COP_MOVB; req1_b = 16'h0B0B;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      fails++;
      $display("FAIL midrst_grant: got %b%b need 01", req1_ready, req0_ready);
    end
    $display("reset mid-op: post-reset conflict grant rdy=%b%b", req1_ready, req0_ready);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rsp0_ready = 1;
    @(negedge clk);
    clear_inputs();
  endtask

`ifdef ALU_COP_CHECK_EN
  task automatic test_cop_check();
    req0_valid = 1; req0_a = 16'h0005; req0_b = 16'h0007; req0_cop = 4'b1000;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b1 || rsp_result !== 16'h0000 || rsp_ovf !== 1'b0 || rsp_err !== 1'b1) begin
      fails++;
      $display("FAIL cop_illegal: got vld %b res %h ovf %b err %b need 1 0000 0 1",
               rsp0_valid, rsp_result, rsp_ovf, rsp_err);
    end
    $display("cop check: cop=1000 -> result=%h err=%b", rsp_result, rsp_err);
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0;
    run_op(1'b1, 16'h0002, 16'h0003, 4'b0110, 16'h0005, 1'b0, "cop_0110");
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_single_op();
    test_overflow();
    test_conflict();
    test_stall();
    test_reset_mid_op();
`ifdef ALU_COP_CHECK_EN
    test_cop_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
